// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional phase-align feature is selected elsewhere with CLK_DIV_SYNC_EN.
package clk_div_pkg;

    localparam int CLK_DIV_MIN = 2;

    // Width of a channel index; a single channel still needs a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending divisor and registered outputs.
// Divisor changes are deferred to the period boundary while the channel runs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_pend,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(clamp_div(32'(DEFAULT_DIV)));

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic [WIDTH-1:0] w_div_in;
    logic             w_last;
    logic             w_restart;

    assign w_div_in  = WIDTH'(clamp_div(32'(i_div)));
    assign w_last    = (r_cnt == r_div - 1'b1);
    assign w_restart = w_last | i_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the pending divisor is reset too, so a write in flight at reset is discarded.
            r_cnt      <= '0;
            r_div      <= RST_DIV;
            r_pend_div <= RST_DIV;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else if (!i_en) begin
            // Idle channel: nothing to keep glitch-free, so divisors land at once.
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
            if (i_wr)
                r_div <= w_div_in;
            else if (r_pend)
                r_div <= r_pend_div;
        end else begin
            // NOTE: non-blocking assignments here, so every test below sees the pre-edge r_cnt/r_div.
            r_clk  <= (r_cnt < (r_div >> 1));
            r_tick <= w_last;
            if (w_restart) begin
                r_cnt <= '0;
                if (r_pend)
                    r_div <= r_pend_div;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A write is only ever accepted with r_pend low, so it cannot clobber a pending value.
            if (i_wr) begin
                r_pend_div <= w_div_in;
                r_pend     <= 1'b1;
            end else if (w_restart) begin
                r_pend     <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider with tick strobes.
// Define CLK_DIV_SYNC_EN to let the sync input phase-align all enabled channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_idx_w(CHANNELS)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]              cfg_div,
    input  logic [CHANNELS-1:0]           ch_en,
    input  logic                          sync,
    output logic [CHANNELS-1:0]           clk_out,
    output logic [CHANNELS-1:0]           tick
);

    localparam int CW = ch_idx_w(CHANNELS);
    localparam int PW = 2 ** CW;

    logic [CHANNELS-1:0] w_pend;
    logic [PW-1:0]       w_pend_pad;
    logic                w_accept;
    logic                w_sync;

    // Unused select codes read a zero pad, so out-of-range writes are accepted and dropped.
    assign w_pend_pad = PW'(w_pend);
    assign cfg_ready  = !w_pend_pad[cfg_ch];
    assign w_accept   = cfg_valid & cfg_ready;

`ifdef CLK_DIV_SYNC_EN
    assign w_sync = sync;
`else
    logic w_unused_sync;
    assign w_unused_sync = sync;
    assign w_sync        = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_div_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (ch_en[i]),
            .i_sync (w_sync),
            .i_wr   (w_accept && (cfg_ch == CW'(i))),
            .i_div  (cfg_div),
            .o_pend (w_pend[i]),
            .o_clk  (clk_out[i]),
            .o_tick (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a period-position model predicts every cycle's outputs.
// Honours CLK_DIV_SYNC_EN the same way as the design.
module tb_clk_div_multi;

    localparam int C  = 6;
    localparam int W  = 8;
    localparam int DD = 2;

`ifdef CLK_DIV_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    typedef struct {
        logic [C-1:0] clk;
        logic [C-1:0] tick;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [2:0]   cfg_ch;
    logic [W-1:0] cfg_div;
    logic [C-1:0] ch_en;
    logic         sync;
    logic [C-1:0] clk_out;
    logic [C-1:0] tick;

    clk_div_multi #(
        .CHANNELS    (C),
        .WIDTH       (W),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .ch_en     (ch_en),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_out[$];
    bit   q_rdy[$];

    // Reference: each running channel sits at a position within its current period.
    int m_div[C];
    int m_pos[C];
    int m_pv[C];
    bit m_pend[C];
    bit m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int clampm(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            m_div[i]  = clampm(DD);
            m_pos[i]  = 0;
            m_pv[i]   = 0;
            m_pend[i] = 1'b0;
        end
        m_acc = 1'b0;
    endtask

    // Predict with the inputs currently driven, then advance one clock.
    task automatic step();
        exp_t e;
        bit   rdy;
        int   ch;
        ch    = int'(cfg_ch);
        rdy   = (ch >= C) ? 1'b1 : !m_pend[ch];
        q_rdy.push_back(rdy);
        m_acc = cfg_valid && rdy && (ch < C);
        e.clk  = '0;
        e.tick = '0;
        for (int i = 0; i < C; i++) begin
            if (!ch_en[i]) begin
                m_pos[i] = 0;
                if (m_acc && ch == i)
                    m_div[i] = clampm(int'(cfg_div));
                else if (m_pend[i])
                    m_div[i] = m_pv[i];
                m_pend[i] = 1'b0;
            end else begin
                e.clk[i]  = (m_pos[i] < m_div[i] / 2);
                e.tick[i] = (m_pos[i] == m_div[i] - 1);
                if (e.tick[i] || (SYNC_ON && sync)) begin
                    m_pos[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i]  = m_pv[i];
                        m_pend[i] = 1'b0;
                    end
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
                if (m_acc && ch == i) begin
                    m_pv[i]   = clampm(int'(cfg_div));
                    m_pend[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        q_out.push_back(e);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write(input int ch, input int d);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = W'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_clk_out"}, clk_out, 0);
        check({name, "_tick"}, tick, 0);
        check({name, "_ready"}, cfg_ready, 1);
        q_out.delete();
        q_rdy.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q_rdy.size() > 0) check("cfg_ready", cfg_ready, q_rdy.pop_front());
        if (q_out.size() > 0) begin
            exp_t e;
            e = q_out.pop_front();
            check("clk_out", clk_out, e.clk);
            check("tick", tick, e.tick);
        end
    end

    initial begin
        bit accepted;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        ch_en     = '0;
        sync      = 1'b0;
        model_reset();
        #1;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Default divisor on channel 0 only.
        ch_en = 6'b000001;
        steps(10);

        // Divisor 15 loaded while idle, then enabled.
        ch_en = '0;
        steps(2);
        write(0, 15);
        ch_en = 6'b000001;
        steps(40);

        // Channel 1 at D=4, mid-period reload to 10, then a stalled write of 6.
        write(1, 4);
        ch_en = 6'b000011;
        steps(5);
        write(1, 10);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 8'd6;
        accepted  = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            step();
            accepted = m_acc;
        end
        cfg_valid = 1'b0;
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL d6_accept: got no accept within 100 cycles, required accept");
        end
        steps(30);

        // Clamp cases and an out-of-range channel select.
        write(2, 0);
        write(3, 1);
        write(7, 9);
        write(6, 5);
        ch_en = 6'b001111;
        steps(20);

        // Reset with a pending divisor outstanding.
        write(0, 5);
        steps(3);
        do_reset("midrst");
        ch_en = 6'b000011;
        steps(12);

        // Two channels at D=6 and D=9 with offset phases, then a sync pulse.
        ch_en = '0;
        steps(1);
        write(4, 6);
        write(5, 9);
        ch_en = 6'b010000;
        steps(3);
        ch_en = 6'b110000;
        steps(7);
        sync = 1'b1;
        step();
        sync = 1'b0;
        steps(25);

        // Randomised traffic.
        ch_en = C'($urandom);
        for (int k = 0; k < 3000; k++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 255))
                                                     : W'($urandom_range(0, 12));
            sync      = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) ch_en = C'($urandom);
            step();
            if ($urandom_range(0, 999) == 0) do_reset("rndrst");
        end
        cfg_valid = 1'b0;
        sync      = 1'b0;

        @(negedge clk);
        #1;
        check("drain_out", q_out.size(), 0);
        check("drain_rdy", q_rdy.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
